conv_line_feeder: RTL and testbench
===================================

CONV_LINE_FEEDER -- requirements
Module: conv_line_feeder

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, pixel and kernel coefficient width.
REQ-002 SHALL have parameter IMG_W, default 16, pixels per image row (valid range 4..256).
REQ-003 SHALL have parameter IMG_H, default 16, rows per frame (valid range 3..256).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle frame start request.
REQ-007 SHALL have port pix_valid, input, 1, host pixel valid.
REQ-008 SHALL have port pix_data, input, BIT_DEPTH, raster-order pixel.
REQ-009 SHALL have port pix_ready, output, 1, feeder accepts a pixel this cycle.
REQ-010 SHALL have port k_we, input, 1, kernel coefficient write enable.
REQ-011 SHALL have port k_waddr, input, 4, kernel write index 0..8.
REQ-012 SHALL have port k_wdata, input, BIT_DEPTH, kernel coefficient.
REQ-013 SHALL have port kernel_addr, input, 4, kernel read index from the convolver.
REQ-014 SHALL have port kernel_in, output, BIT_DEPTH, coefficient at kernel_addr.
REQ-015 SHALL have port shift_buffer, input, 1, convolver request to advance one column.
REQ-016 SHALL have port in_l1, output, BIT_DEPTH, top row pixel of current column.
REQ-017 SHALL have port in_l2, output, BIT_DEPTH, middle row pixel of current column.
REQ-018 SHALL have port in_l3, output, BIT_DEPTH, bottom row pixel of current column.
REQ-019 SHALL have port lines_ready, output, 1, three rows loaded and columns are being served.
REQ-020 SHALL have port line_done, output, 1, one-cycle pulse after the last column of a band.
REQ-021 SHALL have port frame_done, output, 1, one-cycle pulse after the last band of the frame.

Function
REQ-022 SHALL hold three row buffers of IMG_W x BIT_DEPTH, a 2-bit top-row rotation pointer, a column pointer col_ptr, and a band counter.
REQ-023 SHALL implement states IDLE, FILL3, FILL1, SERVE and FDONE.
REQ-024 IDLE: pix_ready=0, lines_ready=0; start -> FILL3 with col_ptr=0, band=0, rotation=0.
REQ-025 FILL3: pix_ready=1; each pix_valid&&pix_ready writes the pixel into row (count/IMG_W) at column (count%IMG_W); after 3*IMG_W accepted pixels -> SERVE.
REQ-026 FILL1: pix_ready=1; IMG_W accepted pixels overwrite the oldest (top) row buffer; on the last pixel rotation advances by one (mod 3) so the new row becomes bottom; -> SERVE.
REQ-027 SERVE: lines_ready=1, pix_ready=0; in_l1/in_l2/in_l3 are registered and present top/middle/bottom row at col_ptr, updated the cycle after entry and the cycle after each accepted shift (one-cycle latency).
REQ-028 SERVE with shift_buffer=1 and col_ptr<IMG_W-1: col_ptr increments by 1.
REQ-029 SERVE with shift_buffer=1 and col_ptr==IMG_W-1: line_done pulses next cycle, col_ptr wraps to 0, band increments; if the completed band was band IMG_H-3 -> FDONE, else -> FILL1.
REQ-030 FDONE: frame_done=1 for exactly one cycle, then -> IDLE.
REQ-031 shift_buffer outside SERVE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-032 pix_valid outside FILL3/FILL1 SHALL be ignored (no write, no count).
REQ-033 Kernel store: nine BIT_DEPTH registers; k_we with k_waddr<=8 writes at clock edge in any state; k_waddr>8 ignored.
REQ-034 kernel_in SHALL be combinational from kernel_addr (same-cycle read); kernel_addr>8 returns 0; simultaneous write and read of one index returns the old value.
REQ-035 Pixel data SHALL be stored unmodified; no arithmetic on pixel values.

Reset
REQ-036 rst=0 at a clock edge SHALL force IDLE, col_ptr=0, band=0, rotation=0, all nine kernel registers=0, and in_l1/in_l2/in_l3, pix_ready, lines_ready, line_done, frame_done, kernel_in-store to 0.
REQ-037 Reset mid-FILL or mid-SERVE SHALL discard the partial frame; row buffer contents need not be cleared.

Verification
REQ-038 Kernel: write 1..9 to indices 0..8, sweep kernel_addr 0..9 -> kernel_in 1..9 then 0.
REQ-039 Fill: IMG_W=16, start, stream pixels 0..47 -> pix_ready drops after 48th; lines_ready=1; in_l1/l2/l3 = 0/16/32.
REQ-040 Shift: 16 shift_buffer pulses -> columns advance to 15/31/47, line_done pulse after 16th, state FILL1; stream 48..63 -> in_l1/l2/l3 = 16/32/48.
REQ-041 Frame: IMG_H=4, full frame with continuous shifts -> exactly two line_done pulses, one frame_done, return to IDLE.
REQ-042 Backpressure/ignore: pix_valid toggling every other cycle in FILL3 -> 48 pixels still accepted correctly; shift_buffer during FILL and start during SERVE -> no effect.
REQ-043 Reset: rst=0 after 20 pixels -> IDLE, outputs 0, kernel registers 0; new start refills from row 0.

Source files
------------

// File: rtl/conv_line_feeder.sv
`default_nettype none
// ============================================================================
// conv_line_feeder
//   Buffers three image rows and serves 3-pixel columns to a 3x3 convolver;
//   also holds the nine kernel coefficients.
//   Revision: 1.0
// ============================================================================
module conv_line_feeder #(
   parameter int BIT_DEPTH = 8,
   parameter int IMG_W     = 16,
   parameter int IMG_H     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pix_valid,
   input  logic [BIT_DEPTH-1:0] pix_data,
   output logic                 pix_ready,
   input  logic                 k_we,
   input  logic [3:0]           k_waddr,
   input  logic [BIT_DEPTH-1:0] k_wdata,
   input  logic [3:0]           kernel_addr,
   output logic [BIT_DEPTH-1:0] kernel_in,
   input  logic                 shift_buffer,
   output logic [BIT_DEPTH-1:0] in_l1,
   output logic [BIT_DEPTH-1:0] in_l2,
   output logic [BIT_DEPTH-1:0] in_l3,
   output logic                 lines_ready,
   output logic                 line_done,
   output logic                 frame_done
);

   localparam int            c_cw        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [c_cw-1:0] c_last_col = c_cw'(IMG_W - 1);
   localparam logic [7:0]    c_last_band = 8'(IMG_H - 3);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL3 = 3'd1,
      S_FILL1 = 3'd2,
      S_SERVE = 3'd3,
      S_FDONE = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [c_cw-1:0]       col_q, col_d;
   logic [7:0]            band_q, band_d;
   logic [1:0]            rot_q, rot_d;
   logic [1:0]            fill_row_q, fill_row_d;
   logic                  line_done_q, line_done_d;
   logic [BIT_DEPTH-1:0]  l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
   logic [BIT_DEPTH-1:0]  kern_q [9];
   logic [BIT_DEPTH-1:0]  kern_d [9];
   logic [BIT_DEPTH-1:0]  row_q [3][IMG_W];
   logic [BIT_DEPTH-1:0]  row_d [3][IMG_W];

   logic                  wr_en;
   logic [1:0]            wr_row;
   logic [1:0]            rot_next;
   logic [1:0]            top_idx, mid_idx, bot_idx;

   assign rot_next = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;

   // rot_q names the physical buffer holding the top row; the other two follow it
   assign top_idx = rot_q;
   assign mid_idx = rot_next;
   assign bot_idx = (rot_q == 2'd0) ? 2'd2 : rot_q - 2'd1;

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      band_d      = band_q;
      rot_d       = rot_q;
      fill_row_d  = fill_row_q;
      line_done_d = 1'b0;
      pix_ready   = 1'b0;
      lines_ready = 1'b0;
      frame_done  = 1'b0;
      wr_en       = 1'b0;
      wr_row      = rot_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FILL3;
               col_d      = '0;
               band_d     = '0;
               rot_d      = '0;
               fill_row_d = '0;
            end
         end
         S_FILL3: begin
            pix_ready = 1'b1;
            wr_row    = fill_row_q;
            if (pix_valid) begin
               wr_en = 1'b1;
               if (col_q == c_last_col) begin
                  col_d      = '0;
                  fill_row_d = fill_row_q + 2'd1;
                  if (fill_row_q == 2'd2) begin
                     state_d = S_SERVE;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_FILL1: begin
            pix_ready = 1'b1;
            wr_row    = rot_q;
            if (pix_valid) begin
               wr_en = 1'b1;
               if (col_q == c_last_col) begin
                  col_d   = '0;
                  rot_d   = rot_next;
                  state_d = S_SERVE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_SERVE: begin
            lines_ready = 1'b1;
            if (shift_buffer) begin
               if (col_q == c_last_col) begin
                  col_d       = '0;
                  band_d      = band_q + 8'd1;
                  line_done_d = 1'b1;
                  state_d     = (band_q == c_last_band) ? S_FDONE : S_FILL1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_FDONE: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      row_d = row_q;
      for (int r = 0; r < 3; r++) begin
         if (wr_en && (wr_row == 2'(r))) begin
            row_d[r][col_q] = pix_data;
         end
      end
   end

   // Column outputs reload from col_q every SERVE cycle, giving one-cycle latency
   always_comb begin
      l1_d = l1_q;
      l2_d = l2_q;
      l3_d = l3_q;
      if (state_q == S_SERVE) begin
         for (int r = 0; r < 3; r++) begin
            if (top_idx == 2'(r)) l1_d = row_q[r][col_q];
            if (mid_idx == 2'(r)) l2_d = row_q[r][col_q];
            if (bot_idx == 2'(r)) l3_d = row_q[r][col_q];
         end
      end
   end

   always_comb begin
      kern_d = kern_q;
      if (k_we) begin
         for (int i = 0; i < 9; i++) begin
            if (k_waddr == 4'(i)) kern_d[i] = k_wdata;
         end
      end
   end

   always_comb begin
      kernel_in = '0;
      for (int i = 0; i < 9; i++) begin
         if (kernel_addr == 4'(i)) kernel_in = kern_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         band_q      <= '0;
         rot_q       <= '0;
         fill_row_q  <= '0;
         line_done_q <= 1'b0;
         l1_q        <= '0;
         l2_q        <= '0;
         l3_q        <= '0;
         for (int i = 0; i < 9; i++) kern_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         band_q      <= band_d;
         rot_q       <= rot_d;
         fill_row_q  <= fill_row_d;
         line_done_q <= line_done_d;
         l1_q        <= l1_d;
         l2_q        <= l2_d;
         l3_q        <= l3_d;
         kern_q      <= kern_d;
      end
   end

   // Row storage is left uncleared by reset; a new frame always refills it
   always_ff @(posedge clk) begin
      row_q <= row_d;
   end

   assign in_l1     = l1_q;
   assign in_l2     = l2_q;
   assign in_l3     = l3_q;
   assign line_done = line_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_line_feeder.sv
`default_nettype none
// ============================================================================
// tb_conv_line_feeder
//   Self-checking bench: kernel table sweep plus scoreboarded column checks.
//   Revision: 1.0
// ============================================================================
module tb_conv_line_feeder;

   localparam int BD = 8;
   localparam int W  = 16;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          pix_valid = 1'b0;
   logic [BD-1:0] pix_data = '0;
   logic          pix_ready;
   logic          k_we = 1'b0;
   logic [3:0]    k_waddr = '0;
   logic [BD-1:0] k_wdata = '0;
   logic [3:0]    kernel_addr = '0;
   logic [BD-1:0] kernel_in;
   logic          shift_buffer = 1'b0;
   logic [BD-1:0] in_l1, in_l2, in_l3;
   logic          lines_ready, line_done, frame_done;

   conv_line_feeder #(.BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .start(start),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .k_we(k_we), .k_waddr(k_waddr), .k_wdata(k_wdata),
      .kernel_addr(kernel_addr), .kernel_in(kernel_in),
      .shift_buffer(shift_buffer),
      .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3),
      .lines_ready(lines_ready), .line_done(line_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    addr;
      logic [BD-1:0] exp;
   } kvec_t;

   typedef struct {
      int            due;
      int            col;
      logic [BD-1:0] t;
      logic [BD-1:0] m;
      logic [BD-1:0] b;
   } col_exp_t;

   col_exp_t sb[$];
   kvec_t    kv[10];
   int errors = 0, checks = 0, cyc = 0;
   int line_cnt = 0, frame_cnt = 0;

   always @(negedge clk) begin
      if (line_done)  line_cnt  = line_cnt + 1;
      if (frame_done) frame_cnt = frame_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Image pixel at (row, col) of a frame whose raster stream starts at base
   function automatic logic [BD-1:0] pv(input int base, input int row, input int col);
      return BD'((base + row * W + col) & 255);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         col_exp_t e;
         e = sb.pop_front();
         chk($sformatf("in_l1 col%0d", e.col), int'(in_l1), int'(e.t));
         chk($sformatf("in_l2 col%0d", e.col), int'(in_l2), int'(e.m));
         chk($sformatf("in_l3 col%0d", e.col), int'(in_l3), int'(e.b));
      end
   endtask

   task automatic push_col(input int base, input int band, input int col, input int delay);
      col_exp_t e;
      e.due = cyc + delay;
      e.col = col;
      e.t   = pv(base, band, col);
      e.m   = pv(base, band + 1, col);
      e.b   = pv(base, band + 2, col);
      sb.push_back(e);
   endtask

   // gap inserts an idle cycle with shift_buffer and start asserted, both of
   // which must be ignored while filling
   task automatic send_pix(input logic [BD-1:0] v, input bit gap);
      int guard;
      if (gap) begin
         pix_valid = 1'b0; shift_buffer = 1'b1; start = 1'b1;
         tick();
         shift_buffer = 1'b0; start = 1'b0;
      end
      pix_valid = 1'b1;
      pix_data  = v;
      guard = 0;
      while (!pix_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!pix_ready) chk("pix_ready timeout", 0, 1);
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic send_row(input int base, input int row, input bit gap);
      for (int c = 0; c < W; c++) send_pix(pv(base, row, c), gap);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pix_ready in FILL3", int'(pix_ready), 1);
   endtask

   task automatic fill3(input int base, input bit gap);
      for (int r = 0; r < 3; r++) send_row(base, r, gap);
      chk("pix_ready after fill", int'(pix_ready), 0);
      chk("lines_ready after fill", int'(lines_ready), 1);
      push_col(base, 0, 0, 1);
   endtask

   task automatic serve_band(input int base, input int band, input int gap);
      for (int c = 1; c < W; c++) begin
         shift_buffer = 1'b1;
         push_col(base, band, c, 2);
         tick();
         shift_buffer = 1'b0;
         for (int g = 0; g < gap; g++) tick();
      end
      shift_buffer = 1'b1;
      tick();
      shift_buffer = 1'b0;
      chk("sb drained", sb.size(), 0);
      chk($sformatf("line_done band%0d", band), int'(line_done), 1);
      chk($sformatf("lines_ready off band%0d", band), int'(lines_ready), 0);
      if (band == H - 3) begin
         chk("frame_done", int'(frame_done), 1);
      end else begin
         chk("frame_done low", int'(frame_done), 0);
         chk("pix_ready in FILL1", int'(pix_ready), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 9; i++) begin
         kv[i].addr = 4'(i);
         kv[i].exp  = BD'(i + 1);
      end
      kv[9].addr = 4'd9;
      kv[9].exp  = '0;

      // Reset state
      repeat (3) tick();
      chk("reset pix_ready", int'(pix_ready), 0);
      chk("reset lines_ready", int'(lines_ready), 0);
      chk("reset line_done", int'(line_done), 0);
      chk("reset frame_done", int'(frame_done), 0);
      chk("reset in_l1", int'(in_l1), 0);
      chk("reset kernel_in", int'(kernel_in), 0);
      rst = 1'b1;
      tick();

      // Kernel store: write 1..9, then sweep the table
      for (int i = 0; i < 9; i++) begin
         k_we = 1'b1; k_waddr = 4'(i); k_wdata = BD'(i + 1);
         tick();
      end
      k_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         kernel_addr = kv[i].addr;
         #1;
         chk($sformatf("kernel addr%0d", kv[i].addr), int'(kernel_in), int'(kv[i].exp));
      end
      kernel_addr = 4'd3;
      k_we = 1'b1; k_waddr = 4'd3; k_wdata = 8'd77;
      #1;
      chk("kernel read-during-write old", int'(kernel_in), 4);
      tick();
      k_we = 1'b0;
      chk("kernel after write", int'(kernel_in), 77);
      k_we = 1'b1; k_waddr = 4'd12; k_wdata = 8'd200;
      tick();
      k_we = 1'b0;
      kernel_addr = 4'd4;
      #1;
      chk("kernel out-of-range write ignored", int'(kernel_in), 5);

      // Frame 1: gapped shifts on band 0, continuous shifts on band 1
      line_cnt = 0; frame_cnt = 0;
      shift_buffer = 1'b1;
      tick();
      shift_buffer = 1'b0;
      chk("shift in IDLE ignored", int'(lines_ready), 0);
      do_start();
      fill3(0, 1'b0);
      serve_band(0, 0, 1);
      send_row(0, 3, 1'b0);
      chk("lines_ready after FILL1", int'(lines_ready), 1);
      push_col(0, 1, 0, 1);
      serve_band(0, 1, 0);
      tick();
      chk("IDLE after FDONE frame_done", int'(frame_done), 0);
      chk("IDLE after FDONE pix_ready", int'(pix_ready), 0);
      chk("IDLE after FDONE lines_ready", int'(lines_ready), 0);
      chk("line_done count", line_cnt, 2);
      chk("frame_done count", frame_cnt, 1);

      // Frame 2: toggling valid with ignored shift/start during fill
      do_start();
      fill3(64, 1'b1);
      tick();
      start = 1'b1;
      push_col(64, 0, 0, 1);
      tick();
      start = 1'b0;
      chk("start in SERVE lines_ready", int'(lines_ready), 1);
      chk("start in SERVE pix_ready", int'(pix_ready), 0);
      serve_band(64, 0, 1);

      // Reset mid-frame, then reset after 20 pixels and refill
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("reset in_l1", int'(in_l1), 0);
      chk("reset in_l2", int'(in_l2), 0);
      chk("reset in_l3", int'(in_l3), 0);
      chk("reset pix_ready mid", int'(pix_ready), 0);
      chk("reset line_done mid", int'(line_done), 0);
      for (int i = 0; i < 9; i++) begin
         kernel_addr = 4'(i);
         #1;
         chk($sformatf("reset kernel%0d", i), int'(kernel_in), 0);
      end
      do_start();
      for (int i = 0; i < 20; i++) send_pix(BD'(200 + i), 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("reset after 20 pix_ready", int'(pix_ready), 0);
      chk("reset after 20 lines_ready", int'(lines_ready), 0);
      do_start();
      fill3(100, 1'b0);
      serve_band(100, 0, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
